// File: rtl/clk_tick_pkg.sv
// Shared constants and types for the prescaled-clock tick/PWM blocks.
// Also used by the prescaler top so both agree on duty width.
package clk_tick_pkg;

  localparam int unsigned WIDTH_DEFAULT   = 8;
  localparam int unsigned SYNC_STAGES_MIN = 2;

  typedef logic [WIDTH_DEFAULT-1:0] duty_t;

endpackage

// File: rtl/clk_sync_edge.sv
// Synchronizes a slow asynchronous level into clk and emits a registered
// one-cycle pulse on each rising edge it sees.
module clk_sync_edge
  import clk_tick_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_last;
      rise_q <= sync_last & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/clk_tick_pwm.sv
// Turns the prescaler's slow square wave into ticks, counts them into a
// free-running period and drives a registered PWM with a shadowed duty.
module clk_tick_pwm
  import clk_tick_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scaled_clk_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             tick,
  output logic             period_done,
  output logic             pwm_out
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_active_q, duty_active_d;
  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic             pending_q, pending_d;
  logic             period_done_q, period_done_d;
  logic             pwm_q, pwm_d;
  logic             wrap;
  logic             boundary;
  logic             xfer;

  clk_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (scaled_clk_in),
    .rise     (tick)
  );

  always_comb begin
    wrap          = tick & (cnt_q == CntMax);
    boundary      = (enable & wrap) | ~enable;
    xfer          = duty_valid & ~pending_q;

    cnt_d         = cnt_q;
    duty_active_d = duty_active_q;
    duty_pend_d   = duty_pend_q;
    pending_d     = pending_q;
    period_done_d = enable & wrap;
    pwm_d         = enable & (cnt_q < duty_active_q);

    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    // A value captured on a boundary edge must wait for the next boundary,
    // so apply only what was already pending before this cycle.
    if (boundary && pending_q) begin
      duty_active_d = duty_pend_q;
      pending_d     = 1'b0;
    end else if (xfer) begin
      duty_pend_d = duty;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      duty_active_q <= '0;
      duty_pend_q   <= '0;
      pending_q     <= 1'b0;
      period_done_q <= 1'b0;
      pwm_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      duty_active_q <= duty_active_d;
      duty_pend_q   <= duty_pend_d;
      pending_q     <= pending_d;
      period_done_q <= period_done_d;
      pwm_q         <= pwm_d;
    end
  end

  assign duty_ready  = ~pending_q;
  assign period_done = period_done_q;
  assign pwm_out     = pwm_q;

endmodule
